rdm_rd_stream: RTL and testbench

Read-side controller for the RDM dual-port SRAM (1152-bit words, 11-bit address). It accepts a burst request (start address, word count) and drives port B (addrb/enb). It captures each 1152-bit doutb word after the SRAM read latency and serialises it into 128-bit beats on a valid/ready stream toward downstream processing. It is the consumer counterpart of the port-A byte-enable write path.

---
 rtl/rdm_rd_stream_if.sv | 39 +++
 rtl/rdm_rd_stream.sv | 148 ++++++++++++++
 tb/tb_rdm_rd_stream.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rdm_rd_stream_if.sv
// ---------------------------------------------------------------------------
// Module      : rdm_rd_stream_if
// Description : Request, SRAM port-B and beat-stream signals of the RDM read
//               streamer. The master modport is the streamer's view.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface rdm_rd_stream_if #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 1152,
  parameter int BEAT_W = 128
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W:0]   req_len;
  logic [ADDR_W-1:0] addrb;
  logic              enb;
  logic [WORD_W-1:0] doutb;
  logic              m_valid;
  logic              m_ready;
  logic [BEAT_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  modport master (
    input  req_valid, req_addr, req_len, doutb, m_ready,
    output req_ready, addrb, enb, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output req_valid, req_addr, req_len, doutb, m_ready,
    input  req_ready, addrb, enb, m_valid, m_data, m_last, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/rdm_rd_stream.sv
// ---------------------------------------------------------------------------
// Module      : rdm_rd_stream
// Description : Burst reader for the RDM SRAM port B; serialises each word
//               into LSB-first beats on a valid/ready stream.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rdm_rd_stream #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 1152,
  parameter int BEAT_W = 128,
  parameter int RD_LAT = 1
) (
  input  logic            sclk,
  input  logic            rst,
  rdm_rd_stream_if.master bus
);

  localparam int BEATS  = WORD_W / BEAT_W;
  localparam int BIDX_W = $clog2(BEATS);

  localparam logic [BIDX_W-1:0] c_last_beat = BIDX_W'(BEATS - 1);
  localparam logic [BIDX_W-1:0] c_beat_one  = BIDX_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_len_one   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   c_len_zero  = '0;
  localparam logic [0:0]        c_lat_init  = 1'(RD_LAT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [0:0]        lat_cnt_q,   lat_cnt_d;
  logic [BIDX_W-1:0] beat_idx_q,  beat_idx_d;
  logic [WORD_W-1:0] word_buf_q,  word_buf_d;
  logic [ADDR_W-1:0] addrb_q,     addrb_d;
  logic              enb_q,       enb_d;
  logic              done_q,      done_d;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      lat_cnt_q   <= '0;
      beat_idx_q  <= '0;
      addrb_q     <= '0;
      enb_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      lat_cnt_q   <= lat_cnt_d;
      beat_idx_q  <= beat_idx_d;
      addrb_q     <= addrb_d;
      enb_q       <= enb_d;
      done_q      <= done_d;
    end
  end

  // The word buffer is only read while streaming, so it needs no reset.
  always_ff @(posedge sclk) begin
    word_buf_q <= word_buf_d;
  end

  // enb/addrb are registered, so they are set on the edge that enters FETCH.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    lat_cnt_d   = lat_cnt_q;
    beat_idx_d  = beat_idx_q;
    word_buf_d  = word_buf_q;
    addrb_d     = addrb_q;
    enb_d       = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cur_addr_d  = bus.req_addr;
          remaining_d = bus.req_len;
          if (bus.req_len == c_len_zero) begin
            done_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            enb_d   = 1'b1;
            addrb_d = bus.req_addr;
          end
        end
      end
      S_FETCH: begin
        state_d   = S_WAIT;
        lat_cnt_d = c_lat_init;
      end
      S_WAIT: begin
        if (lat_cnt_q == 1'b0) begin
          word_buf_d = bus.doutb;
          beat_idx_d = '0;
          state_d    = S_STREAM;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: begin
        if (bus.m_ready) begin
          if (beat_idx_q == c_last_beat) begin
            if (remaining_q > c_len_one) begin
              remaining_d = remaining_q - c_len_one;
              cur_addr_d  = cur_addr_q + c_addr_one;
              addrb_d     = cur_addr_q + c_addr_one;
              enb_d       = 1'b1;
              state_d     = S_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            beat_idx_d = beat_idx_q + c_beat_one;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.m_valid   = (state_q == S_STREAM);
    bus.m_data    = '0;
    if (state_q == S_STREAM) begin
      bus.m_data = word_buf_q[beat_idx_q*BEAT_W +: BEAT_W];
    end
    bus.m_last    = (state_q == S_STREAM) && (beat_idx_q == c_last_beat) &&
                    (remaining_q == c_len_one);
    bus.addrb     = addrb_q;
    bus.enb       = enb_q;
    bus.done      = done_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_rdm_rd_stream.sv
// ---------------------------------------------------------------------------
// Module      : tb_rdm_rd_stream
// Description : Scoreboard bench; one streamer per read latency (1 and 2)
//               sharing stimulus, each with its own SRAM latency model.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rdm_rd_stream;

  typedef struct {
    logic [127:0] d;
    logic         last;
    logic         wend;
  } beat_t;

  logic          sclk = 1'b0;
  logic          rst  = 1'b1;
  logic          req_valid = 1'b0;
  logic [10:0]   req_addr  = '0;
  logic [11:0]   req_len   = '0;
  logic          m_ready   = 1'b0;
  logic          intrude   = 1'b0;

  logic [1:0]    req_valid_w, req_ready_w, busy_w, done_w, enb_w;
  logic [1:0]    m_valid_w, m_last_w;
  logic [10:0]   addrb_w [2];
  logic [127:0]  m_data_w [2];
  logic [1151:0] s1 [2];
  logic [1151:0] s2 [2];
  logic [1151:0] mem [2048];

  beat_t         exp_q  [2][$];
  logic [10:0]   addr_q [2][$];
  int            nxt_v [2], nxt_e [2], exp_done [2], hs_tot [2];
  logic [1:0]    prev_stall, rst_seen;
  logic [127:0]  prev_data [2];
  logic [1:0]    prev_last;
  int            cyc = 0;
  int            checks = 0, errors = 0;
  int            rmode = 0, stall_arm = 0, stall_cnt = 0, hs_base = 0;
  beat_t         e;
  logic [10:0]   mon_a;

  always #5 sclk = ~sclk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    rdm_rd_stream_if #(.ADDR_W(11), .WORD_W(1152), .BEAT_W(128)) bus ();
    assign bus.req_valid   = req_valid | (intrude & busy_w[gi]);
    assign bus.req_addr    = req_addr;
    assign bus.req_len     = req_len;
    assign bus.m_ready     = m_ready;
    assign bus.doutb       = (gi == 0) ? s1[gi] : s2[gi];
    assign req_valid_w[gi] = bus.req_valid;
    assign req_ready_w[gi] = bus.req_ready;
    assign busy_w[gi]      = bus.busy;
    assign done_w[gi]      = bus.done;
    assign enb_w[gi]       = bus.enb;
    assign m_valid_w[gi]   = bus.m_valid;
    assign m_last_w[gi]    = bus.m_last;
    assign addrb_w[gi]     = bus.addrb;
    assign m_data_w[gi]    = bus.m_data;
    rdm_rd_stream #(.ADDR_W(11), .WORD_W(1152), .BEAT_W(128), .RD_LAT(gi + 1)) u_dut (
      .sclk (sclk),
      .rst  (rst),
      .bus  (bus.master)
    );
  end

  // SRAM model: stage 1 loads on enb, stage 2 adds one more cycle of latency.
  always @(posedge sclk) begin
    for (int i = 0; i < 2; i++) begin
      if (enb_w[i]) s1[i] <= mem[addrb_w[i]];
      s2[i] <= s1[i];
    end
  end

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", nm, d, cyc, act, exp);
    end
  endtask

  always @(posedge sclk) begin
    #1;
    if (stall_arm != 0 && hs_tot[0] - hs_base == 4) begin
      stall_cnt = 20;
      stall_arm = 0;
    end
    if (stall_cnt > 0) begin
      m_ready = 1'b0;
      stall_cnt--;
    end else begin
      m_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: timing expectations plus scoreboard pops, once per cycle.
  always @(negedge sclk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        exp_q[i].delete();
        addr_q[i].delete();
        nxt_v[i] = -1; nxt_e[i] = -1; exp_done[i] = -1;
        prev_stall[i] = 1'b0;
        rst_seen[i] = 1'b1;
      end else begin
        if (rst_seen[i]) begin
          chk("rst_m_valid", i, m_valid_w[i], 0);
          chk("rst_m_data", i, m_data_w[i], 0);
          chk("rst_m_last", i, m_last_w[i], 0);
          chk("rst_enb", i, enb_w[i], 0);
          chk("rst_addrb", i, addrb_w[i], 0);
          chk("rst_busy", i, busy_w[i], 0);
          chk("rst_done", i, done_w[i], 0);
          chk("rst_req_ready", i, req_ready_w[i], 1);
          rst_seen[i] = 1'b0;
        end
        if (done_w[i]) begin
          if (exp_done[i] < 0) chk("done_unexpected", i, done_w[i], 0);
          else begin
            chk("done_time", i, cyc, exp_done[i]);
            chk("done_busy", i, busy_w[i], 0);
            exp_done[i] = -1;
          end
        end else if (exp_done[i] >= 0 && cyc > exp_done[i]) begin
          chk("done_missing", i, done_w[i], 1);
          exp_done[i] = -1;
        end
        if (enb_w[i]) begin
          if (nxt_e[i] < 0) chk("enb_unexpected", i, enb_w[i], 0);
          else begin
            chk("enb_time", i, cyc, nxt_e[i]);
            nxt_e[i] = -1;
          end
          if (addr_q[i].size() == 0) chk("enb_extra", i, enb_w[i], 0);
          else chk("addrb", i, addrb_w[i], addr_q[i].pop_front());
        end else if (nxt_e[i] >= 0 && cyc > nxt_e[i]) begin
          chk("enb_missing", i, enb_w[i], 1);
          nxt_e[i] = -1;
        end
        if (nxt_v[i] >= 0) begin
          if (cyc == nxt_v[i]) begin
            chk("valid_time", i, m_valid_w[i], 1);
            nxt_v[i] = -1;
          end else if (m_valid_w[i]) chk("valid_early", i, m_valid_w[i], 0);
        end else if (m_valid_w[i] && exp_q[i].size() == 0) begin
          chk("valid_unexpected", i, m_valid_w[i], 0);
        end
        if (prev_stall[i]) begin
          chk("stall_valid", i, m_valid_w[i], 1);
          chk("stall_data", i, m_data_w[i], prev_data[i]);
          chk("stall_last", i, m_last_w[i], prev_last[i]);
        end
        prev_stall[i] = m_valid_w[i] && !m_ready;
        prev_data[i]  = m_data_w[i];
        prev_last[i]  = m_last_w[i];
        if (m_valid_w[i] && m_ready) begin
          hs_tot[i]++;
          if (exp_q[i].size() == 0) chk("beat_extra", i, m_valid_w[i], 0);
          else begin
            e = exp_q[i].pop_front();
            chk("beat_data", i, m_data_w[i], e.d);
            chk("beat_last", i, m_last_w[i], e.last);
            if (e.last) exp_done[i] = cyc + 1;
            else if (e.wend) begin
              nxt_e[i] = cyc + 1;
              nxt_v[i] = cyc + 3 + i;
            end else nxt_v[i] = cyc + 1;
          end
        end
        if (intrude && busy_w[i]) chk("busy_req_ready", i, req_ready_w[i], 0);
        // Reference: the burst expands to len words, nine 16-byte slices each.
        if (req_valid_w[i] && req_ready_w[i]) begin
          if (req_len == 0) exp_done[i] = cyc + 1;
          else begin
            for (int w = 0; w < int'(req_len); w++) begin
              mon_a = req_addr + 11'(w);
              addr_q[i].push_back(mon_a);
              for (int b = 0; b < 9; b++) begin
                e.d    = mem[mon_a][128*b +: 128];
                e.last = (w == int'(req_len) - 1) && (b == 8);
                e.wend = (b == 8);
                exp_q[i].push_back(e);
              end
            end
            nxt_e[i] = cyc + 1;
            nxt_v[i] = cyc + 3 + i;
          end
        end
      end
    end
  end

  task automatic issue(input logic [10:0] a, input logic [11:0] l);
    @(posedge sclk); #1;
    req_valid = 1'b1; req_addr = a; req_len = l;
    @(posedge sclk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy_w != 2'b00 || exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
            exp_done[0] >= 0 || exp_done[1] >= 0) && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    if (n >= 3000) chk("burst_timeout", 0, busy_w, 0);
    repeat (2) @(negedge sclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 2048; k++)
      for (int j = 0; j < 144; j++)
        mem[k][8*j +: 8] = (k < 16 || k >= 2032) ? 8'((k + j) % 256) : 8'($urandom);
    for (int j = 0; j < 144; j++) mem[100][8*j +: 8] = 8'haa;
    for (int i = 0; i < 2; i++) begin
      nxt_v[i] = -1; nxt_e[i] = -1; exp_done[i] = -1; hs_tot[i] = 0;
    end
    repeat (3) @(posedge sclk);
    #1 rst = 1'b0;
    repeat (2) @(negedge sclk);

    issue(11'd100, 12'd1);
    wait_done();
    issue(11'd2046, 12'd3);
    wait_done();

    rmode = 1; stall_arm = 1; hs_base = hs_tot[0];
    n = hs_tot[1];
    issue(11'd100, 12'd1);
    wait_done();
    chk("hs_count", 0, hs_tot[0] - hs_base, 9);
    chk("hs_count", 1, hs_tot[1] - n, 9);
    rmode = 0;

    issue(11'd5, 12'd0);
    wait_done();
    issue(11'd300, 12'd2);
    req_addr = 11'd777; req_len = 12'd1; intrude = 1'b1;
    wait_done();
    intrude = 1'b0;

    hs_base = hs_tot[0];
    issue(11'd40, 12'd4);
    n = 0;
    do begin
      @(posedge sclk); #1;
      n++;
    end while (hs_tot[0] - hs_base < 14 && n < 500);
    if (n >= 500) chk("reset_point_timeout", 0, hs_tot[0] - hs_base, 14);
    rst = 1'b1;
    @(posedge sclk); #1;
    rst = 1'b0;
    repeat (4) @(negedge sclk);
    wait_done();
    issue(11'd41, 12'd2);
    wait_done();

    repeat (6) begin
      rmode = int'($urandom_range(0, 1));
      issue(11'($urandom_range(0, 2047)), 12'($urandom_range(1, 3)));
      wait_done();
    end

    for (int i = 0; i < 2; i++) begin
      chk("end_beats_left", i, exp_q[i].size(), 0);
      chk("end_addrs_left", i, addr_q[i].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
